// File: rtl/counter_mod_param.sv
// Bounded modulo counter with run-time direction, saturate/wrap mode, sync clear,
// clamped parallel load and a terminal-count pulse that coincides with the wrapped value.
module counter_mod_param #(
  parameter int WIDTH   = 8,
  parameter int MAX_VAL = 100
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_load_val,
  input  logic             i_dir,
  input  logic             i_mode,
  output logic [WIDTH-1:0] o_count,
  output logic             o_tc,
  output logic             o_at_max,
  output logic             o_at_min
);

  localparam logic [WIDTH-1:0] LP_MAX  = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] LP_ZERO = '0;
  localparam logic [WIDTH-1:0] LP_ONE  = WIDTH'(1);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic [WIDTH-1:0] w_load_clamped;
  logic             w_at_max;
  logic             w_at_min;

  assign w_load_clamped = (i_load_val > LP_MAX) ? LP_MAX : i_load_val;
  assign w_at_max       = (r_count >= LP_MAX);
  assign w_at_min       = (r_count == LP_ZERO);

  // Bound checks come before +1/-1, so MAX_VAL = 2**WIDTH-1 never overflows.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= LP_ZERO;
      r_tc    <= 1'b0;
    end else if (i_clr) begin
      r_count <= LP_ZERO;
      r_tc    <= 1'b0;
    end else if (i_load) begin
      r_count <= w_load_clamped;
      r_tc    <= 1'b0;
    end else if (i_en) begin
      if (i_dir) begin
        if (!w_at_max) begin
          r_count <= r_count + LP_ONE;
          r_tc    <= 1'b0;
        end else if (i_mode) begin
          r_count <= LP_ZERO;
          r_tc    <= 1'b1;
        end else begin
          r_count <= LP_MAX;
          r_tc    <= 1'b0;
        end
      end else begin
        if (!w_at_min) begin
          r_count <= r_count - LP_ONE;
          r_tc    <= 1'b0;
        end else if (i_mode) begin
          r_count <= LP_MAX;
          r_tc    <= 1'b1;
        end else begin
          r_count <= LP_ZERO;
          r_tc    <= 1'b0;
        end
      end
    end else begin
      r_tc <= 1'b0;
    end
  end

  assign o_count  = r_count;
  assign o_tc     = r_tc;
  assign o_at_max = w_at_max;
  assign o_at_min = w_at_min;

endmodule
